// File: rtl/matmul_operand_loader_if.sv
// matmul_operand_loader_if: operand beat stream in, assembled tile set out toward the MMA
interface matmul_operand_loader_if #(
  parameter int M = 2,
  parameter int N = 2,
  parameter int K = 2,
  parameter int P = 8
);
  logic [4*P-1:0]        in_data_i;
  logic                  in_valid_i;
  logic                  in_last_i;
  logic                  in_zero_c_i;
  logic                  in_ready_o;
  logic signed [P-1:0]   A_o [M][K];
  logic signed [P-1:0]   B_o [K][N];
  logic signed [4*P-1:0] C_o [M][N];
  logic                  valid_o;
  logic                  ready_i;
  logic                  err_o;
  modport master (
    output in_data_i, in_valid_i, in_last_i, in_zero_c_i, ready_i,
    input  in_ready_o, A_o, B_o, C_o, valid_o, err_o
  );
  modport slave (
    input  in_data_i, in_valid_i, in_last_i, in_zero_c_i, ready_i,
    output in_ready_o, A_o, B_o, C_o, valid_o, err_o
  );
endinterface

// File: rtl/matmul_operand_loader.sv
// matmul_operand_loader: assembles A, B, C tiles from a beat stream and issues them as one MMA transaction
module matmul_operand_loader #(
  parameter int M = 2,
  parameter int N = 2,
  parameter int K = 2,
  parameter int P = 8
) (
  input logic clk_i,
  input logic rst_ni,
  matmul_operand_loader_if.slave bus
);
  localparam int D = M > N ? (M > K ? M : K) : (N > K ? N : K);
  localparam int W = D > 1 ? $clog2(D) : 1;
  typedef enum logic [1:0] {LOAD_A, LOAD_B, LOAD_C, ISSUE} state_t;
  state_t state, state_n;
  logic [W-1:0] row, col, row_last, col_last;
  logic zero_c, err, accept, phase_end, exp_last;
  logic signed [P-1:0]   a_q [M][K];
  logic signed [P-1:0]   b_q [K][N];
  logic signed [4*P-1:0] c_q [M][N];
  assign bus.in_ready_o = state != ISSUE;
  assign bus.valid_o    = state == ISSUE;
  assign bus.err_o      = err;
  assign bus.A_o        = a_q;
  assign bus.B_o        = b_q;
  assign bus.C_o        = c_q;
  always_comb begin
    row_last  = state == LOAD_B ? W'(K - 1) : W'(M - 1);
    col_last  = state == LOAD_A ? W'(K - 1) : W'(N - 1);
    accept    = bus.in_valid_i && state != ISSUE;
    phase_end = row == row_last && col == col_last;
    exp_last  = phase_end && (state == LOAD_C || (state == LOAD_B && zero_c));
    state_n   = state;
    if (state == ISSUE)
      state_n = bus.ready_i ? LOAD_A : ISSUE;
    else if (accept && phase_end)
      state_n = state == LOAD_A ? LOAD_B : (state == LOAD_B && !zero_c) ? LOAD_C : ISSUE;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= LOAD_A;
      row    <= '0;
      col    <= '0;
      zero_c <= 1'b0;
      err    <= 1'b0;
      for (int r = 0; r < M; r++) for (int c = 0; c < K; c++) a_q[r][c] <= '0;
      for (int r = 0; r < K; r++) for (int c = 0; c < N; c++) b_q[r][c] <= '0;
      for (int r = 0; r < M; r++) for (int c = 0; c < N; c++) c_q[r][c] <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        col <= col == col_last ? '0 : col + 1'b1;
        row <= col == col_last ? (row == row_last ? '0 : row + 1'b1) : row;
        if (bus.in_last_i != exp_last) err <= 1'b1;
        if (state == LOAD_A) begin
          a_q[row][col] <= bus.in_data_i[P-1:0];
          if (row == '0 && col == '0) zero_c <= bus.in_zero_c_i;
        end
        if (state == LOAD_B) b_q[row][col] <= bus.in_data_i[P-1:0];
        if (state == LOAD_C) c_q[row][col] <= bus.in_data_i;
        // skipped C phase: the tile set goes out with an all-zero accumulator
        if (state == LOAD_B && phase_end && zero_c)
          for (int r = 0; r < M; r++) for (int c = 0; c < N; c++) c_q[r][c] <= '0;
      end
    end
  end
endmodule

// File: tb/tb_matmul_operand_loader.sv
// tb_matmul_operand_loader: randomized beat streams checked every cycle against a beat-count tile model
module tb_matmul_operand_loader;
  localparam int M = 2, N = 2, K = 2, P = 8;
  localparam int NA = M * K, NB = K * N, NC = M * N;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;
  matmul_operand_loader_if #(.M(M), .N(N), .K(K), .P(P)) bus ();
  matmul_operand_loader #(.M(M), .N(N), .K(K), .P(P)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
  int checks = 0;
  int failures = 0;
  logic [7:0]  ma [M][K];
  logic [7:0]  mb [K][N];
  logic [31:0] mc [M][N];
  bit m_issue, m_err, m_zero;
  int cnt, issued, taken;
  bit rand_rdy = 0;
  int gap_max = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int r = 0; r < M; r++) for (int c = 0; c < K; c++) ma[r][c] = '0;
    for (int r = 0; r < K; r++) for (int c = 0; c < N; c++) mb[r][c] = '0;
    for (int r = 0; r < M; r++) for (int c = 0; c < N; c++) mc[r][c] = '0;
    m_issue = 0; m_err = 0; m_zero = 0; cnt = 0;
  endtask
  // Model: position in the tile set is just the count of accepted beats
  always @(negedge clk) begin
    int tot;
    if (!rst_n) model_reset();
    chk("valid_o", bus.valid_o, m_issue);
    chk("err_o", bus.err_o, m_err);
    if (rst_n) chk("in_ready_o", bus.in_ready_o, !m_issue);
    for (int r = 0; r < M; r++) for (int c = 0; c < K; c++) chk($sformatf("A[%0d][%0d]", r, c), $unsigned(bus.A_o[r][c]), ma[r][c]);
    for (int r = 0; r < K; r++) for (int c = 0; c < N; c++) chk($sformatf("B[%0d][%0d]", r, c), $unsigned(bus.B_o[r][c]), mb[r][c]);
    for (int r = 0; r < M; r++) for (int c = 0; c < N; c++) chk($sformatf("C[%0d][%0d]", r, c), $unsigned(bus.C_o[r][c]), mc[r][c]);
    if (!rst_n) begin
    end else if (m_issue) begin
      if (bus.ready_i) begin m_issue = 0; taken++; end
    end else if (bus.in_valid_i) begin
      if (cnt == 0) m_zero = bus.in_zero_c_i;
      tot = m_zero ? NA + NB : NA + NB + NC;
      if (cnt < NA) ma[cnt / K][cnt % K] = bus.in_data_i[7:0];
      else if (cnt < NA + NB) mb[(cnt - NA) / N][(cnt - NA) % N] = bus.in_data_i[7:0];
      else mc[(cnt - NA - NB) / N][(cnt - NA - NB) % N] = bus.in_data_i;
      if (bus.in_last_i != (cnt == tot - 1)) m_err = 1;
      if (cnt == tot - 1) begin
        if (m_zero) for (int r = 0; r < M; r++) for (int c = 0; c < N; c++) mc[r][c] = '0;
        m_issue = 1; cnt = 0; issued++;
      end else cnt++;
    end
  end
  task automatic step();
    @(posedge clk);
    #2;
    if (rand_rdy) bus.ready_i = 1'($urandom_range(0, 1));
  endtask
  task automatic beat(input logic [31:0] d, input logic last, input logic zc);
    bit acc = 0;
    int g = 0;
    if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin bus.in_valid_i = 0; step(); end
    bus.in_valid_i = 1; bus.in_data_i = d; bus.in_last_i = last; bus.in_zero_c_i = zc;
    while (!acc && g < 200) begin
      @(negedge clk);
      acc = bus.in_ready_o;
      step();
      g++;
    end
    if (!acc) begin
      checks++; failures++;
      $display("FAIL beat_accept timeout waiting for in_ready_o");
    end
    bus.in_valid_i = 0;
  endtask
  task automatic send_set(input logic [31:0] a [NA], input logic [31:0] b [NB], input logic [31:0] c [NC],
                          input bit zc, input int bad);
    int tot = zc ? NA + NB : NA + NB + NC;
    logic [31:0] d;
    for (int i = 0; i < tot; i++) begin
      d = $urandom;
      if (i < NA) d[7:0] = a[i][7:0];
      else if (i < NA + NB) d[7:0] = b[i - NA][7:0];
      else d = c[i - NA - NB];
      beat(d, (i == tot - 1) || (i == bad), i == 0 ? zc : 1'($urandom_range(0, 1)));
    end
  endtask
  logic [31:0] va [NA], vb [NB], vc [NC];
  task automatic rand_tile();
    for (int i = 0; i < NA; i++) va[i] = $urandom;
    for (int i = 0; i < NB; i++) vb[i] = $urandom;
    for (int i = 0; i < NC; i++) vc[i] = $urandom;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.in_valid_i = 0; bus.in_data_i = '0; bus.in_last_i = 0; bus.in_zero_c_i = 0; bus.ready_i = 1;
    issued = 0; taken = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    step();
    chk("reset_ready", bus.in_ready_o, 1);
    // directed set with hand-computed expectations
    va = '{1, 2, 3, 4}; vb = '{5, 6, 7, 8}; vc = '{10, 20, 30, 40};
    send_set(va, vb, vc, 0, -1);
    chk("t1_valid", bus.valid_o, 1);
    chk("t1_A10", $unsigned(bus.A_o[1][0]), 3);
    chk("t1_B01", $unsigned(bus.B_o[0][1]), 6);
    chk("t1_C11", $unsigned(bus.C_o[1][1]), 40);
    chk("t1_err", bus.err_o, 0);
    step();
    chk("t1_valid_one_cycle", bus.valid_o, 0);
    // zero_c skip: C must clear from the previous 10..40
    va = '{9, 8, 7, 6}; vb = '{-1, -2, 3, 4};
    send_set(va, vb, vc, 1, -1);
    chk("t2_valid", bus.valid_o, 1);
    chk("t2_ready_low", bus.in_ready_o, 0);
    chk("t2_C00", $unsigned(bus.C_o[0][0]), 0);
    chk("t2_C11", $unsigned(bus.C_o[1][1]), 0);
    step();
    // ready_i low in ISSUE while beats are offered
    bus.ready_i = 0;
    rand_tile();
    send_set(va, vb, vc, 0, -1);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid_i = 1; bus.in_data_i = $urandom; bus.in_last_i = 0; bus.in_zero_c_i = 0;
      step();
    end
    chk("t3_valid_held", bus.valid_o, 1);
    bus.ready_i = 1;
    bus.in_data_i = 32'h0000_005A;
    step();
    step();
    bus.in_valid_i = 0;
    chk("t3_A00", $unsigned(bus.A_o[0][0]), 8'h5A);
    for (int i = 1; i < NA + NB + NC; i++) beat($urandom, i == NA + NB + NC - 1, 0);
    // back-to-back random sets with input gaps and random ready_i
    rand_rdy = 1; gap_max = 3;
    for (int s = 0; s < 3; s++) begin
      rand_tile();
      send_set(va, vb, vc, $urandom_range(0, 3) == 0, -1);
    end
    rand_rdy = 0; gap_max = 0; bus.ready_i = 1;
    step(); step();
    // spurious in_last_i on beat 5
    chk("t5_err_before", bus.err_o, 0);
    rand_tile();
    send_set(va, vb, vc, 0, 4);
    chk("t5_err", bus.err_o, 1);
    chk("t5_valid", bus.valid_o, 1);
    step();
    // reset in the middle of LOAD_B
    va = '{11, 12, 13, 14}; vb = '{15, 16, 17, 18};
    for (int i = 0; i < 6; i++) beat(i < NA ? va[i] : vb[i - NA], 0, 0);
    rst_n = 0;
    #1;
    chk("t6_A00_rst", $unsigned(bus.A_o[0][0]), 0);
    chk("t6_err_rst", bus.err_o, 0);
    step(); step();
    rst_n = 1;
    step();
    rand_tile();
    send_set(va, vb, vc, 0, -1);
    chk("t6_valid", bus.valid_o, 1);
    step(); step();
    chk("sets_issued", issued, 9);
    chk("sets_taken", taken, 9);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
